ps2_rx_fifo: RTL
================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver: synchronises and de-glitches ps2_clk/ps2_data, deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop) with a frame FSM and an inactivity timeout, and buffers valid scan codes in a configurable-depth first-word-fall-through FIFO.
Successor to the fixed 8-deep keyboard receiver. Adds:
- selectable overflow policy
- sticky parity and framing error flags
- FIFO fill level output
Sits between the PS/2 pins and keyboard-decoding logic (scan-code FSM, display drivers).

Parameters:
DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries (legal 1..6)
FILTER_LEN, 4, consecutive equal synchronised ps2_clk samples needed to change filtered clock (legal 1..15)
TIMEOUT, 5000, clk cycles without a filtered falling edge that abort a partial frame (legal 16..65535)
OVF_MODE, 0, 0 = drop incoming code when full; 1 = overwrite oldest entry

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ps2_clk  in  1  asynchronous PS/2 clock pin
ps2_data  in  1  asynchronous PS/2 data pin
rd_en  in  1  pop head entry; ignored when valid=0
clr_err  in  1  one-cycle pulse, clears overflow/parity_err/frame_err
data  out  8  head FIFO entry, meaningful only when valid=1
valid  out  1  FIFO non-empty
level  out  DEPTH_LOG2+1  number of stored entries, 0..2**DEPTH_LOG2
overflow  out  1  sticky: a code was dropped (mode 0) or overwritten (mode 1)
parity_err  out  1  sticky: a frame failed odd parity
frame_err  out  1  sticky: bad stop bit or timeout
busy  out  1  frame FSM not IDLE
sampling  out  1  one-cycle strobe on each filtered ps2_clk falling edge (debug)

Behaviour:
- Reset (rst=1 at posedge clk):
  - FIFO pointers and level = 0; valid=0; all sticky flags 0; busy=0; sampling=0; FSM=IDLE.
  - Sync flops and filtered clock = 1; timeout counter = 0.
  - Reset mid-frame discards the partial frame; FIFO contents are lost.
- Input path:
  - 2-flop synchronisers on both pins.
  - Filter counts consecutive synchronised ps2_clk samples differing from the filtered value; on reaching FILTER_LEN, the filtered value flips and the count clears. Any equal sample clears the count.
  - sampling = registered filtered 1->0 transition.
  - ps2_data is sampled from its synchroniser on the sampling cycle.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur on sampling cycles except timeout.
  - IDLE: data=0 -> DATA, bit index=0. data=1 -> stay in IDLE, no error.
  - DATA: shift bit into position index; after index 7 -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: always -> IDLE.
    - data=1 and ^{data[7:0],parity}=1 -> push code.
    - data=1 with bad parity -> parity_err=1, no push.
    - data=0 -> frame_err=1, no push (parity not checked).
- Timeout:
  - Counter clears on every sampling cycle and while in IDLE; otherwise increments.
  - Reaching TIMEOUT-1 -> IDLE, frame_err=1, partial frame discarded.
  - Timeout has priority over a simultaneous sampling strobe.
- Latency: push is written at the posedge ending the STOP sampling cycle; valid/level/data update at that same edge, i.e. visible the cycle after the strobe.
- FIFO (FWFT):
  - data = storage[rd_ptr]; valid = (level != 0).
  - Pointers wrap modulo depth.
  - Pop when rd_en & valid: rd_ptr+1, level-1.
- Push/pop interactions:
  - Push while not full: wr_ptr+1, level+1.
  - Simultaneous push and pop with level>0: both execute, level unchanged, no overflow (including when full).
  - Push when level=0 with rd_en=1: rd_en ignored, level -> 1.
  - Push when full without pop, OVF_MODE=0: code dropped, overflow=1, pointers unchanged.
  - Push when full without pop, OVF_MODE=1: entry at wr_ptr overwritten, both pointers +1, level stays full, overflow=1.
- Sticky flags:
  - clr_err clears all three flags.
  - A set event in the same cycle as clr_err wins (flag = 1).
  - Receiver keeps operating with flags set; overflow does not stall reception.

Test Plan:
- Frame start0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1 -> one sampling pulse per bit; next cycle after 11th pulse: valid=1, data=8'h1C, level=1; rd_en one cycle -> valid=0, level=0.
- Same frame with parity 1 -> no push, parity_err=1, level=0. Then stop bit 0 on a good frame -> frame_err=1. clr_err pulse -> all flags 0.
- OVF_MODE=0, DEPTH_LOG2=3: send codes 8'h01..8'h09 with no reads -> level=8, overflow=1. Reads return 01..08 in order, then valid=0.
- OVF_MODE=1: same stimulus -> level=8, overflow=1, reads return 02..09. Also: full FIFO plus rd_en in the STOP-push cycle -> level stays 8, overflow stays 0.
- Start bit + 4 data bits, then ps2_clk held high for TIMEOUT+10 cycles -> busy falls, frame_err=1. A following full 8'h5A frame is received intact.
- FILTER_LEN=4: ps2_clk low glitches of 1-3 clk cycles -> sampling never asserts, busy=0. rst asserted mid-frame -> all outputs at reset values next cycle, and the next full frame is received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin sync, clock de-glitch, 11-bit deframing,
// inactivity timeout, and a first-word-fall-through scan-code FIFO.
module ps2_rx_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 5000,
    parameter int OVF_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [7:0]            data,
    output logic                  valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy,
    output logic                  sampling
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int FL1   = FILTER_LEN - 1;
    localparam int TM1   = TIMEOUT - 1;
    localparam logic [3:0]  FLT_MAX = FL1[3:0];
    localparam logic [15:0] TMO_MAX = TM1[15:0];
    localparam logic [DEPTH_LOG2:0] LVL_FULL = DEPTH[DEPTH_LOG2:0];
    localparam bit OVW = (OVF_MODE != 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic       r_clk_s1, r_clk_s2;
    logic       r_dat_s1, r_dat_s2;
    logic       r_fclk;
    logic [3:0] r_fcnt;
    logic       r_sampling;

    logic [1:0]  r_state;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic        r_par;
    logic [15:0] r_tcnt;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_ovf, r_perr, r_ferr;

    logic w_bit, w_tmo, w_stop, w_par_ok;
    logic w_push, w_perr_set, w_ferr_set;
    logic w_full, w_pop, w_ovf_set, w_wr;

    // Synchronisers and clock filter; sampling marks a filtered falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_fclk     <= 1'b1;
            r_fcnt     <= '0;
            r_sampling <= 1'b0;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_dat_s1   <= ps2_data;
            r_dat_s2   <= r_dat_s1;
            r_sampling <= 1'b0;
            if (r_clk_s2 == r_fclk) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FLT_MAX) begin
                r_fcnt     <= '0;
                r_fclk     <= ~r_fclk;
                r_sampling <= r_fclk;
            end else begin
                r_fcnt <= r_fcnt + 4'd1;
            end
        end
    end

    assign w_bit    = r_dat_s2;
    assign w_tmo    = (r_state != S_IDLE) && (r_tcnt == TMO_MAX);
    assign w_stop   = r_sampling && !w_tmo && (r_state == S_STOP);
    assign w_par_ok = ^{r_shift, r_par};

    assign w_push     = w_stop && w_bit && w_par_ok;
    assign w_perr_set = w_stop && w_bit && !w_par_ok;
    assign w_ferr_set = (w_stop && !w_bit) || w_tmo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tcnt  <= '0;
        end else begin
            if (r_sampling || (r_state == S_IDLE) || w_tmo)
                r_tcnt <= '0;
            else
                r_tcnt <= r_tcnt + 16'd1;

            // Timeout beats a coincident strobe.
            if (w_tmo) begin
                r_state <= S_IDLE;
            end else if (r_sampling) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (!w_bit) begin
                            r_state <= S_DATA;
                            r_idx   <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shift[r_idx] <= w_bit;
                        r_idx          <= r_idx + 3'd1;
                        if (r_idx == 3'd7)
                            r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_par   <= w_bit;
                        r_state <= S_STOP;
                    end
                    S_STOP: r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign w_full    = (r_level == LVL_FULL);
    assign w_pop     = rd_en && (r_level != '0);
    assign w_ovf_set = w_push && w_full && !w_pop;
    assign w_wr      = w_push && (!w_full || w_pop || OVW);

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop || (w_ovf_set && OVW))
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_full && !w_pop)
                r_level <= r_level + 1'b1;
            else if (w_pop && !w_push)
                r_level <= r_level - 1'b1;

            // Set events win over a coincident clear.
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (clr_err)
                r_ovf <= 1'b0;
            if (w_perr_set)
                r_perr <= 1'b1;
            else if (clr_err)
                r_perr <= 1'b0;
            if (w_ferr_set)
                r_ferr <= 1'b1;
            else if (clr_err)
                r_ferr <= 1'b0;
        end
    end

    assign data       = r_mem[r_rd_ptr];
    assign valid      = (r_level != '0);
    assign level      = r_level;
    assign overflow   = r_ovf;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign busy       = (r_state != S_IDLE);
    assign sampling   = r_sampling;

endmodule
